ge_seq_ctrl: RTL and testbench

- Sequencer for the graduation-exam stage datapath: runs a game of NUM_STAGES stages in order.
- Per stage it accepts player input (effort, hard) over a valid/ready handshake and supplies a random value from an internal LFSR.
- It drives the combinational stage datapath, registers the returned pass/bonus and chains them into the next stage.
- Reports the final result; aborts on a failed stage or on input timeout.

---
 rtl/ge_pkg.sv | 23 ++
 rtl/ge_lfsr5.sv | 27 ++
 rtl/ge_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ge_seq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ge_pkg.sv
// Shared types and constants for the graduation-exam stage sequencer.
package ge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IN = 2'd1,
        EVAL    = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int EFFORT_W = 7;
    localparam int HARD_W   = 5;
    localparam int RAND_W   = 5;
    localparam int BONUS_W  = 2;

    localparam logic [RAND_W-1:0] LFSR_SEED_DEF = 5'b10101;

    // Fibonacci step with taps on bits 4 and 2 (maximal length, period 31).
    function automatic logic [RAND_W-1:0] lfsr5_next(input logic [RAND_W-1:0] cur);
        return {cur[3:0], cur[4] ^ cur[2]};
    endfunction

endpackage

// File: rtl/ge_lfsr5.sv
// 5-bit random source; steps only when adv is high, reseeded only by reset.
module ge_lfsr5
    import ge_pkg::*;
#(
    parameter logic [RAND_W-1:0] SEED = LFSR_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    output logic [RAND_W-1:0] q
);

    logic [RAND_W-1:0] lfsr_q;
    logic [RAND_W-1:0] lfsr_d;

    assign lfsr_d = adv ? lfsr5_next(lfsr_q) : lfsr_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;

endmodule

// File: rtl/ge_seq_ctrl.sv
// Runs NUM_STAGES exam stages through an external combinational datapath,
// chaining pass/bonus between stages and aborting on failure or input timeout.
module ge_seq_ctrl
    import ge_pkg::*;
#(
    parameter int                NUM_STAGES = 3,
    parameter int                TIMEOUT    = 63,
    parameter logic [RAND_W-1:0] LFSR_SEED  = LFSR_SEED_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EFFORT_W-1:0] effort,
    input  logic [HARD_W-1:0]   hard,
    output logic [1:0]          dp_stage,
    output logic                dp_pass_prev,
    output logic [BONUS_W-1:0]  dp_bonus_prev,
    output logic [EFFORT_W-1:0] dp_effort,
    output logic [HARD_W-1:0]   dp_hard,
    output logic [RAND_W-1:0]   dp_random,
    input  logic                dp_pass,
    input  logic [BONUS_W-1:0]  dp_bonus,
    output logic                busy,
    output logic                done,
    output logic                final_pass,
    output logic [BONUS_W-1:0]  final_bonus,
    output logic [1:0]          fail_stage,
    output logic                timeout
);

    state_e state_q, state_d;

    logic [1:0]          stage_q, stage_d;
    logic [7:0]          timer_q, timer_d;
    logic                pass_q, pass_d;
    logic [BONUS_W-1:0]  bonus_q, bonus_d;
    logic [EFFORT_W-1:0] eff_q, eff_d;
    logic [HARD_W-1:0]   hard_q, hard_d;
    logic [RAND_W-1:0]   rand_q, rand_d;
    logic                fpass_q, fpass_d;
    logic [BONUS_W-1:0]  fbonus_q, fbonus_d;
    logic [1:0]          fstage_q, fstage_d;
    logic                tout_q, tout_d;

    logic [RAND_W-1:0] lfsr_val;
    logic              hs;
    logic              timer_expired;
    logic              last_stage;

    assign hs            = (state_q == WAIT_IN) && in_valid;
    assign timer_expired = (timer_q == 8'(TIMEOUT));
    assign last_stage    = (stage_q == 2'(NUM_STAGES - 1));

    ge_lfsr5 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (hs),
        .q     (lfsr_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WAIT_IN;
            WAIT_IN: if (hs) state_d = EVAL;
                     else if (timer_expired) state_d = DONE;
            EVAL:    if (!dp_pass || last_stage) state_d = DONE;
                     else state_d = WAIT_IN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == WAIT_IN);
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
    end

    always_comb begin
        stage_d  = stage_q;
        timer_d  = timer_q;
        pass_d   = pass_q;
        bonus_d  = bonus_q;
        eff_d    = eff_q;
        hard_d   = hard_q;
        rand_d   = rand_q;
        fpass_d  = fpass_q;
        fbonus_d = fbonus_q;
        fstage_d = fstage_q;
        tout_d   = tout_q;
        case (state_q)
            IDLE: if (start) begin
                stage_d  = '0;
                pass_d   = 1'b1;
                bonus_d  = '0;
                timer_d  = '0;
                tout_d   = 1'b0;
                fpass_d  = 1'b0;
                fbonus_d = '0;
                fstage_d = '0;
            end
            WAIT_IN: begin
                // A handshake on the expiry cycle still counts as in time.
                if (hs) begin
                    eff_d   = effort;
                    hard_d  = hard;
                    rand_d  = lfsr_val;
                    timer_d = '0;
                end else if (timer_expired) begin
                    tout_d   = 1'b1;
                    fpass_d  = 1'b0;
                    fstage_d = stage_q;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            EVAL: begin
                pass_d  = dp_pass;
                bonus_d = dp_bonus;
                if (!dp_pass) begin
                    fpass_d  = 1'b0;
                    fbonus_d = dp_bonus;
                    fstage_d = stage_q;
                end else if (last_stage) begin
                    fpass_d  = 1'b1;
                    fbonus_d = dp_bonus;
                end else begin
                    stage_d = stage_q + 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q  <= '0;
            timer_q  <= '0;
            pass_q   <= 1'b0;
            bonus_q  <= '0;
            eff_q    <= '0;
            hard_q   <= '0;
            rand_q   <= '0;
            fpass_q  <= 1'b0;
            fbonus_q <= '0;
            fstage_q <= '0;
            tout_q   <= 1'b0;
        end else begin
            stage_q  <= stage_d;
            timer_q  <= timer_d;
            pass_q   <= pass_d;
            bonus_q  <= bonus_d;
            eff_q    <= eff_d;
            hard_q   <= hard_d;
            rand_q   <= rand_d;
            fpass_q  <= fpass_d;
            fbonus_q <= fbonus_d;
            fstage_q <= fstage_d;
            tout_q   <= tout_d;
        end
    end

    assign dp_stage      = stage_q;
    assign dp_pass_prev  = pass_q;
    assign dp_bonus_prev = bonus_q;
    assign dp_effort     = eff_q;
    assign dp_hard       = hard_q;
    assign dp_random     = rand_q;
    assign final_pass    = fpass_q;
    assign final_bonus   = fbonus_q;
    assign fail_stage    = fstage_q;
    assign timeout       = tout_q;

endmodule

// File: tb/tb_ge_seq_ctrl.sv
// Directed bench for ge_seq_ctrl with a table-driven combinational datapath stub.
module tb_ge_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] effort;
    logic [4:0] hard;
    logic [1:0] dp_stage;
    logic       dp_pass_prev;
    logic [1:0] dp_bonus_prev;
    logic [6:0] dp_effort;
    logic [4:0] dp_hard;
    logic [4:0] dp_random;
    logic       dp_pass;
    logic [1:0] dp_bonus;
    logic       busy;
    logic       done;
    logic       final_pass;
    logic [1:0] final_bonus;
    logic [1:0] fail_stage;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    logic       stub_pass  [4];
    logic [1:0] stub_bonus [4];

    // Observations collected per game by run_game.
    int         n_eval, n_done, n_hs, done_cyc;
    logic [4:0] ev_rand  [4];
    logic [1:0] ev_stage [4];
    logic       ev_ppass [4];
    logic [1:0] ev_pbonus[4];
    logic [6:0] ev_eff   [4];
    logic [4:0] ev_hard  [4];

    always #5 clk = ~clk;

    always_comb begin
        dp_pass  = stub_pass[dp_stage];
        dp_bonus = stub_bonus[dp_stage];
    end

    ge_seq_ctrl #(.NUM_STAGES(3), .TIMEOUT(63), .LFSR_SEED(5'b10101)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .effort        (effort),
        .hard          (hard),
        .dp_stage      (dp_stage),
        .dp_pass_prev  (dp_pass_prev),
        .dp_bonus_prev (dp_bonus_prev),
        .dp_effort     (dp_effort),
        .dp_hard       (dp_hard),
        .dp_random     (dp_random),
        .dp_pass       (dp_pass),
        .dp_bonus      (dp_bonus),
        .busy          (busy),
        .done          (done),
        .final_pass    (final_pass),
        .final_bonus   (final_bonus),
        .fail_stage    (fail_stage),
        .timeout       (timeout)
    );

    task automatic set_stub(input logic [3:0] p, input logic [7:0] b);
        for (int i = 0; i < 4; i++) begin
            stub_pass[i]  = p[i];
            stub_bonus[i] = b[2*i +: 2];
        end
    endtask

    // Starts a game at a falling edge and samples every following falling edge.
    // Cycle k is the k-th cycle after the one in which start was sampled.
    task automatic run_game(input bit start_hold, input int valid_from, input int max_cyc);
        n_eval = 0; n_done = 0; n_hs = 0; done_cyc = 0;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; effort = 7'h40; hard = 5'd0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (!start_hold) start = 1'b0;
            in_valid = (k >= valid_from);
            effort   = 7'(8'h40 + k);
            hard     = 5'(k);
            if (in_ready && in_valid) n_hs++;
            if (busy && !in_ready && !done && n_eval < 4) begin
                ev_rand[n_eval]   = dp_random;
                ev_stage[n_eval]  = dp_stage;
                ev_ppass[n_eval]  = dp_pass_prev;
                ev_pbonus[n_eval] = dp_bonus_prev;
                ev_eff[n_eval]    = dp_effort;
                ev_hard[n_eval]   = dp_hard;
                n_eval++;
            end
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = k;
                start = 1'b0;
            end
            if (done_cyc != 0 && k >= done_cyc + 2) break;
        end
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; effort = '0; hard = '0;
        set_stub(4'b1111, 8'h55);
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, in_ready, final_pass, final_bonus, fail_stage, timeout} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_status: got %b expected 0",
                     {busy, done, in_ready, final_pass, final_bonus, fail_stage, timeout});
        end
        n_checks++;
        if ({dp_stage, dp_pass_prev, dp_bonus_prev, dp_effort, dp_hard, dp_random} !== 22'b0) begin
            n_fail++;
            $display("FAIL reset_dp: got %h expected 0",
                     {dp_stage, dp_pass_prev, dp_bonus_prev, dp_effort, dp_hard, dp_random});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_pass;
        set_stub(4'b1111, 8'b01_01_01_01);
        run_game(1'b0, 1, 20);
        n_checks++;
        if (done_cyc !== 7 || n_done !== 1) begin
            n_fail++;
            $display("FAIL full_done: cycle %0d pulses %0d, expected cycle 7 pulses 1", done_cyc, n_done);
        end
        n_checks++;
        if (n_eval !== 3 || ev_rand[0] !== 5'b10101 || ev_rand[1] !== 5'b01010 || ev_rand[2] !== 5'b10100) begin
            n_fail++;
            $display("FAIL full_random: n=%0d got %b %b %b expected 10101 01010 10100",
                     n_eval, ev_rand[0], ev_rand[1], ev_rand[2]);
        end
        n_checks++;
        if (ev_stage[0] !== 2'd0 || ev_stage[1] !== 2'd1 || ev_stage[2] !== 2'd2) begin
            n_fail++;
            $display("FAIL full_stage: got %0d %0d %0d expected 0 1 2", ev_stage[0], ev_stage[1], ev_stage[2]);
        end
        n_checks++;
        if (ev_eff[0] !== 7'h41 || ev_eff[2] !== 7'h45 || ev_hard[1] !== 5'd3) begin
            n_fail++;
            $display("FAIL full_latch: eff %h/%h hard %0d expected 41/45 hard 3", ev_eff[0], ev_eff[2], ev_hard[1]);
        end
        n_checks++;
        if ({busy, final_pass, final_bonus, fail_stage, timeout} !== 7'b0_1_01_00_0) begin
            n_fail++;
            $display("FAIL full_result: got %b expected 0101000",
                     {busy, final_pass, final_bonus, fail_stage, timeout});
        end
    endtask

    task automatic test_fail_stage1;
        set_stub(4'b1101, 8'b01_01_10_01);
        run_game(1'b0, 1, 20);
        n_checks++;
        if (done_cyc !== 5 || n_hs !== 2 || n_eval !== 2) begin
            n_fail++;
            $display("FAIL fail1_flow: done %0d hs %0d evals %0d expected 5 2 2", done_cyc, n_hs, n_eval);
        end
        n_checks++;
        if ({final_pass, final_bonus, fail_stage, timeout} !== 6'b0_10_01_0) begin
            n_fail++;
            $display("FAIL fail1_result: got %b expected 010010",
                     {final_pass, final_bonus, fail_stage, timeout});
        end
        n_checks++;
        if (ev_rand[0] !== 5'b01000 || ev_rand[1] !== 5'b10000) begin
            n_fail++;
            $display("FAIL fail1_random: got %b %b expected 01000 10000", ev_rand[0], ev_rand[1]);
        end
    endtask

    task automatic test_chaining;
        set_stub(4'b1111, 8'b00_10_00_11);
        run_game(1'b0, 1, 20);
        n_checks++;
        if (ev_ppass[0] !== 1'b1 || ev_pbonus[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL chain_stage0: prev %b/%b expected 1/00", ev_ppass[0], ev_pbonus[0]);
        end
        n_checks++;
        if (ev_ppass[1] !== 1'b1 || ev_pbonus[1] !== 2'b11 || ev_stage[1] !== 2'd1) begin
            n_fail++;
            $display("FAIL chain_stage1: prev %b/%b stage %0d expected 1/11 stage 1",
                     ev_ppass[1], ev_pbonus[1], ev_stage[1]);
        end
        n_checks++;
        if (ev_pbonus[2] !== 2'b00 || final_bonus !== 2'b10 || final_pass !== 1'b1) begin
            n_fail++;
            $display("FAIL chain_final: prev %b final %b/%b expected 00 1/10",
                     ev_pbonus[2], final_pass, final_bonus);
        end
    endtask

    task automatic test_back_to_back;
        set_stub(4'b1111, 8'h00);
        run_game(1'b1, 1, 20);
        n_checks++;
        if (done_cyc !== 7 || n_done !== 1 || n_eval !== 3) begin
            n_fail++;
            $display("FAIL busy_start: done %0d pulses %0d evals %0d expected 7 1 3", done_cyc, n_done, n_eval);
        end
        n_checks++;
        if (ev_rand[0] !== 5'b01001) begin
            n_fail++;
            $display("FAIL b2b_game1_random: got %b expected 01001", ev_rand[0]);
        end
        run_game(1'b0, 1, 20);
        n_checks++;
        if (ev_rand[0] !== 5'b01011 || done_cyc !== 7) begin
            n_fail++;
            $display("FAIL b2b_game2: random %b done %0d expected 01011 7", ev_rand[0], done_cyc);
        end
    endtask

    task automatic test_timeout;
        set_stub(4'b1111, 8'h00);
        run_game(1'b0, 1000, 100);
        n_checks++;
        if (done_cyc !== 65 || n_hs !== 0) begin
            n_fail++;
            $display("FAIL timeout_cycle: done %0d hs %0d expected 65 0", done_cyc, n_hs);
        end
        n_checks++;
        if ({timeout, final_pass, fail_stage} !== 4'b1_0_00) begin
            n_fail++;
            $display("FAIL timeout_result: got %b expected 1000", {timeout, final_pass, fail_stage});
        end
        run_game(1'b0, 64, 100);
        n_checks++;
        if (done_cyc !== 70 || n_hs !== 3) begin
            n_fail++;
            $display("FAIL timeout_edge_flow: done %0d hs %0d expected 70 3", done_cyc, n_hs);
        end
        n_checks++;
        if ({timeout, final_pass} !== 2'b01 || ev_rand[0] !== 5'b11001) begin
            n_fail++;
            $display("FAIL timeout_edge_result: to/pass %b random %b expected 01 11001",
                     {timeout, final_pass}, ev_rand[0]);
        end
    endtask

    task automatic test_reset_mid_eval;
        int seen_done;
        set_stub(4'b1111, 8'h55);
        @(negedge clk); start = 1'b1; in_valid = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (!(busy && !in_ready && dp_stage == 2'd1)) begin
            n_fail++;
            $display("FAIL rst_mid_setup: busy %b ready %b stage %0d expected EVAL of stage 1",
                     busy, in_ready, dp_stage);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, in_ready, final_pass, final_bonus, fail_stage, timeout,
             dp_stage, dp_pass_prev, dp_bonus_prev, dp_effort, dp_hard, dp_random} !== 31'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h expected 0",
                     {busy, done, in_ready, final_pass, final_bonus, fail_stage, timeout,
                      dp_stage, dp_pass_prev, dp_bonus_prev, dp_effort, dp_hard, dp_random});
        end
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        seen_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: %0d active cycles after reset, expected 0", seen_done);
        end
        run_game(1'b0, 1, 20);
        n_checks++;
        if (ev_rand[0] !== 5'b10101 || done_cyc !== 7) begin
            n_fail++;
            $display("FAIL rst_mid_reseed: random %b done %0d expected 10101 7", ev_rand[0], done_cyc);
        end
    endtask

    initial begin
        test_reset;
        test_full_pass;
        test_fail_stage1;
        test_chaining;
        test_back_to_back;
        test_timeout;
        test_reset_mid_eval;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
